// File: rtl/pref_pkg.sv
// pref_pkg: shared types, channel ids and helpers for the L2 stride prefetcher
package pref_pkg;
    localparam int PREF_ADDR_WIDTH   = 32;
    localparam int PREF_LINE_OFFSET  = 6;
    localparam int PREF_STRIDE_WIDTH = 16;
    localparam int PREF_LINE_WIDTH   = PREF_ADDR_WIDTH - PREF_LINE_OFFSET;
    localparam logic CH_INST = 1'b0;
    localparam logic CH_DATA = 1'b1;
    typedef logic [PREF_LINE_WIDTH-1:0] line_t;
    typedef logic signed [PREF_STRIDE_WIDTH-1:0] stride_t;
    typedef logic [1:0] conf_t;
    typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;
    function automatic conf_t conf_sat_inc(input conf_t c);
        return (c == 2'd3) ? c : c + 2'd1;
    endfunction
endpackage

// File: rtl/pref_fifo.sv
// pref_fifo: synchronous request FIFO with flush; flush wins over push and pop
module pref_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty   = wr_ptr == rd_ptr;
    assign dout    = mem[rd_ptr[PW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (PW+1)'(do_push);
            rd_ptr <= rd_ptr + (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end
endmodule

// File: rtl/l2_stride_prefetcher.sv
// l2_stride_prefetcher: per-channel stride learner feeding a queued L2 prefetch port
module l2_stride_prefetcher
    import pref_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_OFFSET  = 6,
    parameter int STRIDE_WIDTH = 16,
    parameter int DEGREE       = 2,
    parameter int QDEPTH       = 4,
    parameter int CONF_TH      = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  miss_valid,
    input  logic                  miss_type,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    output logic                  req_pref_l2cache,
    output logic                  type_pref_l2cache,
    output logic [ADDR_WIDTH-1:0] addr_pref_l2cache,
    input  logic                  complete_l2cache_pref,
    input  logic                  hit_l2cache_pref,
    input  logic                  miss_l2cache_pref,
    output logic [31:0]           pref_issued_cnt,
    output logic [31:0]           pref_hit_cnt
);
    localparam int LW = ADDR_WIDTH - LINE_OFFSET;
    logic [1:0]                     tbl_valid;
    logic [LW-1:0]                  tbl_last [2];
    logic signed [STRIDE_WIDTH-1:0] tbl_stride [2];
    conf_t                          tbl_conf [2];
    logic [LW-1:0]                  line;
    logic signed [STRIDE_WIDTH-1:0] delta;
    conf_t                          conf_next;
    logic                           trigger;
    logic                           unused_offset;
    logic                           gen_busy, gen_type;
    logic [2:0]                     gen_k;
    logic [LW-1:0]                  gen_line, gen_step;
    logic [ADDR_WIDTH:0]            q_dout;
    logic                           q_full, q_empty, pop;
    state_t                         state, next_state;

    assign unused_offset = ^miss_addr[LINE_OFFSET-1:0];

    always_comb begin
        line      = miss_addr[ADDR_WIDTH-1:LINE_OFFSET];
        delta     = STRIDE_WIDTH'(line - tbl_last[miss_type]);
        conf_next = conf_sat_inc(tbl_conf[miss_type]);
        trigger   = miss_valid && tbl_valid[miss_type] && (delta != '0) &&
                    (delta == tbl_stride[miss_type]) && (conf_next >= 2'(CONF_TH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tbl_valid <= '0;
            for (int c = 0; c < 2; c++) begin
                tbl_last[c]   <= '0;
                tbl_stride[c] <= '0;
                tbl_conf[c]   <= '0;
            end
        end else if (miss_valid) begin
            if (!tbl_valid[miss_type]) begin
                tbl_valid[miss_type]  <= 1'b1;
                tbl_last[miss_type]   <= line;
                tbl_stride[miss_type] <= '0;
                tbl_conf[miss_type]   <= '0;
            end else if (delta == '0) begin
                tbl_last[miss_type] <= tbl_last[miss_type];
            end else if (delta == tbl_stride[miss_type]) begin
                tbl_conf[miss_type] <= conf_next;
                tbl_last[miss_type] <= line;
            end else begin
                tbl_stride[miss_type] <= delta;
                tbl_conf[miss_type]   <= '0;
                tbl_last[miss_type]   <= line;
            end
        end
    end

    // Generator walks base+k*stride; a demand flush cancels it, triggers while busy are lost
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gen_busy <= 1'b0;
            gen_type <= 1'b0;
            gen_k    <= '0;
            gen_line <= '0;
            gen_step <= '0;
        end else if (miss_l2cache_pref) begin
            gen_busy <= 1'b0;
        end else if (gen_busy) begin
            gen_line <= gen_line + gen_step;
            gen_k    <= gen_k + 3'd1;
            gen_busy <= gen_k != 3'(DEGREE);
        end else if (trigger) begin
            gen_busy <= 1'b1;
            gen_type <= miss_type;
            gen_k    <= 3'd1;
            gen_step <= LW'(delta);
            gen_line <= line + LW'(delta);
        end
    end

    pref_fifo #(.WIDTH(ADDR_WIDTH + 1), .DEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (gen_busy),
        .pop   (pop),
        .flush (miss_l2cache_pref),
        .din   ({gen_type, gen_line, {LINE_OFFSET{1'b0}}}),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );

    always_comb begin
        pop        = (state == ST_IDLE) && !q_empty && !miss_l2cache_pref;
        next_state = (state == ST_IDLE) ? (pop ? ST_REQ : ST_IDLE)
                                        : (complete_l2cache_pref ? ST_IDLE : ST_REQ);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= ST_IDLE;
            type_pref_l2cache <= 1'b0;
            addr_pref_l2cache <= '0;
            pref_issued_cnt   <= '0;
            pref_hit_cnt      <= '0;
        end else begin
            state <= next_state;
            if (pop) begin
                {type_pref_l2cache, addr_pref_l2cache} <= q_dout;
                pref_issued_cnt <= pref_issued_cnt + 32'd1;
            end
            if (state == ST_REQ && complete_l2cache_pref && hit_l2cache_pref)
                pref_hit_cnt <= pref_hit_cnt + 32'd1;
        end
    end

    assign req_pref_l2cache = state == ST_REQ;
endmodule

// File: tb/tb_l2_stride_prefetcher.sv
// tb_l2_stride_prefetcher: directed and random checks against a queue-based reference model
module tb_l2_stride_prefetcher;
    localparam int QDEPTH = 4, DEGREE = 2, CONF_TH = 2;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        miss_valid = 1'b0, miss_type = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        complete_l2cache_pref = 1'b0, hit_l2cache_pref = 1'b0, miss_l2cache_pref = 1'b0;
    logic        req_pref_l2cache, type_pref_l2cache;
    logic [31:0] addr_pref_l2cache, pref_issued_cnt, pref_hit_cnt;
    int          n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    l2_stride_prefetcher #(
        .ADDR_WIDTH(32), .LINE_OFFSET(6), .STRIDE_WIDTH(16),
        .DEGREE(DEGREE), .QDEPTH(QDEPTH), .CONF_TH(CONF_TH)
    ) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .miss_valid            (miss_valid),
        .miss_type             (miss_type),
        .miss_addr             (miss_addr),
        .req_pref_l2cache      (req_pref_l2cache),
        .type_pref_l2cache     (type_pref_l2cache),
        .addr_pref_l2cache     (addr_pref_l2cache),
        .complete_l2cache_pref (complete_l2cache_pref),
        .hit_l2cache_pref      (hit_l2cache_pref),
        .miss_l2cache_pref     (miss_l2cache_pref),
        .pref_issued_cnt       (pref_issued_cnt),
        .pref_hit_cnt          (pref_hit_cnt)
    );

    // Reference model state: spec-level table, candidate list and request queue
    bit          m_req, m_type;
    logic [31:0] m_addr;
    int unsigned m_issued, m_hits;
    bit          m_valid [2];
    int unsigned m_last [2];
    int          m_stride [2];
    int          m_conf [2];
    logic [32:0] m_fifo [$];
    logic [32:0] m_gen [$];
    logic [32:0] obs [$];
    bit          prev_req;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_type = 0; m_addr = '0; m_issued = 0; m_hits = 0;
        for (int c = 0; c < 2; c++) begin
            m_valid[c] = 0; m_last[c] = 0; m_stride[c] = 0; m_conf[c] = 0;
        end
        m_fifo.delete(); m_gen.delete();
    endtask

    task automatic model_step(input bit mv, input bit mt, input logic [31:0] ma,
                              input bit cmp, input bit hit, input bit ml2);
        bit busy = m_gen.size() != 0;
        bit full = m_fifo.size() >= QDEPTH;
        bit trig = 0;
        logic [32:0] c;
        if (m_req) begin
            if (cmp) begin
                m_req = 0;
                if (hit) m_hits++;
            end
        end else if (m_fifo.size() != 0 && !ml2) begin
            c = m_fifo.pop_front();
            m_type = c[32]; m_addr = c[31:0]; m_req = 1; m_issued++;
        end
        if (mv) begin
            int unsigned line = ma >> 6;
            int d = int'(shortint'(line - m_last[mt]));
            if (!m_valid[mt]) begin
                m_valid[mt] = 1; m_last[mt] = line; m_stride[mt] = 0; m_conf[mt] = 0;
            end else if (d != 0) begin
                if (d == m_stride[mt]) begin
                    m_conf[mt] = (m_conf[mt] < 3) ? m_conf[mt] + 1 : 3;
                    trig = m_conf[mt] >= CONF_TH;
                end else begin
                    m_stride[mt] = d; m_conf[mt] = 0;
                end
                m_last[mt] = line;
            end
        end
        if (ml2) begin
            m_fifo.delete(); m_gen.delete();
        end else begin
            if (busy) begin
                c = m_gen.pop_front();
                if (!full) m_fifo.push_back(c);
            end
            if (trig && !busy)
                for (int k = 1; k <= DEGREE; k++)
                    m_gen.push_back({mt, 26'((ma >> 6) + k * m_stride[mt]), 6'b0});
        end
    endtask

    task automatic compare_all();
        check("req", req_pref_l2cache, m_req);
        check("type", type_pref_l2cache, m_type);
        check("addr", addr_pref_l2cache, m_addr);
        check("issued", pref_issued_cnt, m_issued);
        check("hits", pref_hit_cnt, m_hits);
        if (req_pref_l2cache && !prev_req) obs.push_back({type_pref_l2cache, addr_pref_l2cache});
        prev_req = req_pref_l2cache;
    endtask

    task automatic cycle(input bit mv, input bit mt, input logic [31:0] ma,
                         input bit cmp, input bit hit, input bit ml2);
        miss_valid = mv; miss_type = mt; miss_addr = ma;
        complete_l2cache_pref = cmp; hit_l2cache_pref = hit; miss_l2cache_pref = ml2;
        @(posedge clk);
        model_step(mv, mt, ma, cmp, hit, ml2);
        @(negedge clk);
        compare_all();
    endtask

    // cm: 0 never complete, 1 complete with random hit, 2 complete with hit on the first three requests
    function automatic bit hit_for(input int cm);
        return (cm == 2) ? bit'(m_issued < 4) : bit'($urandom % 2);
    endfunction

    task automatic run(input int n, input int cm);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, cm != 0, hit_for(cm), 0);
    endtask

    task automatic miss(input bit mt, input logic [31:0] ma, input int cm);
        cycle(1, mt, ma, cm != 0, hit_for(cm), 0);
    endtask

    task automatic do_reset();
        rstn = 0; miss_valid = 0; complete_l2cache_pref = 0; miss_l2cache_pref = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        prev_req = 0;
        compare_all();
        rstn = 1;
        obs.delete();
    endtask

    initial begin
        logic [31:0] r_addr [2];
        int          r_stride [2];
        @(negedge clk);
        do_reset();

        // positive data stride
        miss(1, 32'h1000, 1); miss(1, 32'h1040, 1); miss(1, 32'h1080, 1); miss(1, 32'h10C0, 1);
        run(12, 1);
        check("s1_n", obs.size(), 2);
        check("s1_a0", obs[0], {1'b1, 32'h1100});
        check("s1_a1", obs[1], {1'b1, 32'h1140});

        // negative instruction stride
        do_reset();
        miss(0, 32'h2000, 1); miss(0, 32'h1F80, 1); miss(0, 32'h1F00, 1); miss(0, 32'h1E80, 1);
        run(12, 1);
        check("s2_n", obs.size(), 2);
        check("s2_a0", obs[0], {1'b0, 32'h1E00});
        check("s2_a1", obs[1], {1'b0, 32'h1D80});

        // interleaved channels; the data trigger landing while busy is lost
        do_reset();
        miss(0, 32'h4000, 1); miss(1, 32'h8000, 1); miss(0, 32'h4040, 1); miss(1, 32'h8080, 1);
        miss(0, 32'h4080, 1); miss(1, 32'h8100, 1); miss(0, 32'h40C0, 1); miss(1, 32'h8180, 1);
        run(3, 1);
        miss(1, 32'h8200, 1);
        run(12, 1);
        check("s3_n", obs.size(), 4);
        check("s3_a0", obs[0], {1'b0, 32'h4100});
        check("s3_a1", obs[1], {1'b0, 32'h4140});
        check("s3_a2", obs[2], {1'b1, 32'h8280});
        check("s3_a3", obs[3], {1'b1, 32'h8300});

        // broken stride resets confidence and relearns stride 6
        do_reset();
        miss(1, 32'h1000, 1); miss(1, 32'h1040, 1); miss(1, 32'h1080, 1); miss(1, 32'h1200, 1);
        run(10, 1);
        check("s4_none", obs.size(), 0);
        miss(1, 32'h1380, 1); miss(1, 32'h1500, 1);
        run(12, 1);
        check("s4_n", obs.size(), 2);
        check("s4_a0", obs[0], {1'b1, 32'h1680});
        check("s4_a1", obs[1], {1'b1, 32'h1800});

        // demand flush with two queued entries during a request
        do_reset();
        miss(1, 32'h1000, 0); miss(1, 32'h1040, 0); miss(1, 32'h1080, 0); miss(1, 32'h10C0, 0);
        run(4, 0);
        cycle(0, 0, '0, 1, 0, 0);
        run(3, 0);
        miss(1, 32'h1100, 0);
        run(3, 0);
        cycle(0, 0, '0, 0, 0, 1);
        run(2, 0);
        check("s5_held", req_pref_l2cache, 1'b1);
        check("s5_addr", addr_pref_l2cache, 32'h1140);
        cycle(0, 0, '0, 1, 1, 0);
        run(10, 1);
        check("s5_n", obs.size(), 2);
        check("s5_a0", obs[0], {1'b1, 32'h1100});
        check("s5_idle", req_pref_l2cache, 1'b0);

        // counters, then asynchronous reset in the middle of a request
        do_reset();
        miss(1, 32'h1000, 2); miss(1, 32'h1040, 2); miss(1, 32'h1080, 2); miss(1, 32'h10C0, 2);
        run(3, 2);
        miss(1, 32'h1100, 2);
        run(12, 2);
        check("cnt_issued", pref_issued_cnt, 32'd4);
        check("cnt_hit", pref_hit_cnt, 32'd3);
        miss(1, 32'h1140, 0);
        run(3, 0);
        check("pre_rst_req", req_pref_l2cache, 1'b1);
        #2 rstn = 0;
        #1;
        check("rst_req", req_pref_l2cache, 1'b0);
        check("rst_type", type_pref_l2cache, 1'b0);
        check("rst_addr", addr_pref_l2cache, 32'h0);
        check("rst_issued", pref_issued_cnt, 32'h0);
        check("rst_hit", pref_hit_cnt, 32'h0);
        @(negedge clk);
        do_reset();

        // random strided streams with backpressure and flushes
        for (int c = 0; c < 2; c++) begin
            r_addr[c] = $urandom & ~32'h3F;
            r_stride[c] = 1;
        end
        for (int i = 0; i < 3000; i++) begin
            bit ch = 1'($urandom % 2);
            bit mv = 1'($urandom % 2);
            if ($urandom % 24 == 0) begin
                r_stride[ch] = int'($urandom_range(6, 0)) - 3;
                r_addr[ch] = $urandom & ~32'h3F;
            end
            if (mv) r_addr[ch] = r_addr[ch] + 32'(r_stride[ch] * 64);
            cycle(mv, ch, r_addr[ch] | 32'($urandom % 64), ($urandom % 4) == 0,
                  1'($urandom % 2), ($urandom % 40) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
